// File: rtl/arp_crypto_check_pkg.sv
// arp_crypto_check_pkg: shared constants, FSM states and beat record for the ARP key checker
package arp_crypto_check_pkg;
   localparam int          AXIS_DATA_W      = 256;
   localparam int          AXIS_USER_W      = 128;
   localparam int          AXIS_KEEP_W      = AXIS_DATA_W / 8;
   localparam logic [15:0] ETHERTYPE_ARP_LE = 16'h0608;
   localparam int          KEY_LO_BIT       = 80;
   localparam int          KEY_HI_BIT       = 207;
   localparam int          KEY_BYTES        = 16;
   localparam int          KEY_END_BYTE     = (KEY_HI_BIT + 1) / 8;
   localparam logic [31:0] ARP_LAST_TKEEP   = 32'h0000_03FF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_EMIT,
      ST_PASS,
      ST_DROP
   } state_t;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0] tdata;
      logic [AXIS_KEEP_W-1:0] tkeep;
      logic [AXIS_USER_W-1:0] tuser;
      logic                   tlast;
   } beat_t;

   // The ethertype sits byte-swapped in bytes 12..13 of the first beat
   function automatic logic is_arp(input logic [AXIS_DATA_W-1:0] d);
      return d[111:96] == ETHERTYPE_ARP_LE;
   endfunction
endpackage

// File: rtl/arp_crypto_check_if.sv
// arp_crypto_check_if: one AXI-Stream channel with master/slave views
interface arp_crypto_check_if
   import arp_crypto_check_pkg::*;
#(
   parameter int DATA_W = AXIS_DATA_W,
   parameter int USER_W = AXIS_USER_W
) ();
   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic [USER_W-1:0]   tuser;
   logic                tvalid;
   logic                tready;
   logic                tlast;

   modport master (output tdata, output tkeep, output tuser, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tkeep, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/arp_crypto_check_sat_counter.sv
// arp_sat_counter: event counter that sticks at all ones; clear wins over increment
module arp_sat_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_inc,
   input  logic                 i_clr,
   output logic [CNT_WIDTH-1:0] o_cnt
);
   logic [CNT_WIDTH-1:0] r_cnt;

   // count events, hold at the top, clear on request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    r_cnt <= '0;
      else if (i_clr)                r_cnt <= '0;
      else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/arp_crypto_check.sv
// arp_crypto_check: verifies the key in ARP beat 2, strips it on match, drops the packet otherwise
module arp_crypto_check
   import arp_crypto_check_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int CNT_WIDTH            = 32
) (
   input  logic                      axis_aclk,
   input  logic                      axis_resetn,
   arp_crypto_check_if.slave         s_axis,
   arp_crypto_check_if.master        m_axis,
   input  logic [8*KEY_BYTES-1:0]    key_i,
   input  logic                      enable_i,
   input  logic                      clear_counters,
   output logic [CNT_WIDTH-1:0]      arp_ok_cnt,
   output logic [CNT_WIDTH-1:0]      arp_drop_cnt
);
   state_t r_state, w_next;
   beat_t  r_out, r_hold1, r_hold2, w_in, w_load_beat;
   logic   r_out_valid, r_h2_end, r_live;
   logic   w_out_free, w_ready, w_acc, w_sop_arp, w_match;
   logic   w_load, w_cap1, w_cap2, w_ok_inc, w_drop_inc;

   assign w_in       = {s_axis.tdata[C_S_AXIS_DATA_WIDTH-1:0], s_axis.tkeep,
                        s_axis.tuser[C_S_AXIS_TUSER_WIDTH-1:0], s_axis.tlast};
   assign w_out_free = !r_out_valid || m_axis.tready;
   // r_live keeps tready low while reset is asserted and for the first edge after it
   assign w_ready    = r_live && (r_state == ST_EMIT ? 1'b0 : r_state == ST_DROP ? 1'b1 : w_out_free);
   assign w_acc      = s_axis.tvalid && w_ready;
   assign w_sop_arp  = is_arp(w_in.tdata) && enable_i;
   assign w_match    = (w_in.tdata[KEY_HI_BIT:KEY_LO_BIT] == key_i) && (&w_in.tkeep[KEY_END_BYTE-1:0]);

   // next state, output-register load selection and counter events
   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_load_beat = w_in;
      w_cap1      = 1'b0;
      w_cap2      = 1'b0;
      w_ok_inc    = 1'b0;
      w_drop_inc  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_acc && w_sop_arp) begin
               if (w_in.tlast) w_drop_inc = 1'b1;
               else begin
                  w_cap1 = 1'b1;
                  w_next = ST_CHECK;
               end
            end else if (w_acc) begin
               w_load = 1'b1;
               w_next = w_in.tlast ? ST_IDLE : ST_PASS;
            end
         end
         ST_CHECK: begin
            if (w_acc && w_match) begin
               w_load                  = 1'b1;
               w_load_beat             = r_hold1;
               w_load_beat.tuser[15:0] = r_hold1.tuser[15:0] - 16'(KEY_BYTES);
               w_cap2                  = 1'b1;
               w_ok_inc                = 1'b1;
               w_next                  = ST_EMIT;
            end else if (w_acc) begin
               w_drop_inc = 1'b1;
               w_next     = w_in.tlast ? ST_IDLE : ST_DROP;
            end
         end
         ST_EMIT: begin
            if (w_out_free) begin
               w_load      = 1'b1;
               w_load_beat = r_hold2;
               w_next      = r_h2_end ? ST_IDLE : ST_DROP;
            end
         end
         ST_PASS: begin
            if (w_acc) begin
               w_load = 1'b1;
               w_next = w_in.tlast ? ST_IDLE : ST_PASS;
            end
         end
         ST_DROP: begin
            if (w_acc && w_in.tlast) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // state register; any partial packet is abandoned on reset
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_state <= ST_IDLE;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_live  <= 1'b1;
      end
   end

   // one-entry output register, held while downstream stalls
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_out       <= w_load_beat;
         r_out_valid <= 1'b1;
      end else if (m_axis.tready) begin
         r_out_valid <= 1'b0;
      end
   end

   // hold the ARP header beat until the key is judged, then the trimmed tail beat
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_hold1  <= '0;
         r_hold2  <= '0;
         r_h2_end <= 1'b0;
      end else begin
         if (w_cap1) r_hold1 <= w_in;
         if (w_cap2) begin
            r_hold2  <= {AXIS_DATA_W'(w_in.tdata[KEY_LO_BIT-1:0]), ARP_LAST_TKEEP, w_in.tuser, 1'b1};
            r_h2_end <= w_in.tlast;
         end
      end
   end

   assign s_axis.tready = w_ready;
   assign m_axis.tdata  = r_out.tdata[C_M_AXIS_DATA_WIDTH-1:0];
   assign m_axis.tkeep  = r_out.tkeep;
   assign m_axis.tuser  = r_out.tuser[C_M_AXIS_TUSER_WIDTH-1:0];
   assign m_axis.tlast  = r_out.tlast;
   assign m_axis.tvalid = r_out_valid;

   arp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ok (
      .clk   (axis_aclk),
      .rst_n (axis_resetn),
      .i_inc (w_ok_inc),
      .i_clr (clear_counters),
      .o_cnt (arp_ok_cnt)
   );

   arp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop (
      .clk   (axis_aclk),
      .rst_n (axis_resetn),
      .i_inc (w_drop_inc),
      .i_clr (clear_counters),
      .o_cnt (arp_drop_cnt)
   );
endmodule
